// File: rtl/game_pkg.sv
// Shared types and widths for the game sequencing logic.
package game_pkg;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LIVES_W = 2;
    localparam int unsigned LEVEL_W = 2;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_PAUSE = 3'd1,
        S_PLAY  = 3'd2,
        S_DEAD  = 3'd3,
        S_WIN   = 3'd4
    } state_t;

endpackage

// File: rtl/edge_detect.sv
// One-bit rising-edge detector; RESET_VAL=1 suppresses an edge for a level held through reset.
module edge_detect #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= RESET_VAL;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game phase sequencer: title, serve pause, play, game-over and victory, with lives/level tracking.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int unsigned LIVES        = 3,
    parameter int unsigned LEVELS       = 3,
    parameter int unsigned PAUSE_FRAMES = 60,
    parameter int unsigned HOLD_FRAMES  = 120
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               ball_lost,
    input  logic               bricks_clear,
    output logic               init,
    output logic               dead,
    output logic               win,
    output logic               play,
    output logic               serve,
    output logic               reset_field,
    output logic [LIVES_W-1:0] lives,
    output logic [LEVEL_W-1:0] level
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(LEVELS - 1);
    localparam logic [CNT_W-1:0]   PAUSE_CNT  = CNT_W'(PAUSE_FRAMES);
    localparam logic [CNT_W-1:0]   HOLD_CNT   = CNT_W'(HOLD_FRAMES);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               serve_q, serve_d;
    logic               reset_field_q, reset_field_d;
    logic               start_edge;

    edge_detect #(
        .RESET_VAL (1'b1)
    ) u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (start_btn),
        .rise  (start_edge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_INIT;
            cnt_q         <= '0;
            lives_q       <= LIVES_INIT;
            level_q       <= '0;
            serve_q       <= 1'b0;
            reset_field_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            serve_q       <= serve_d;
            reset_field_q <= reset_field_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        lives_d       = lives_q;
        level_d       = level_q;
        serve_d       = 1'b0;
        reset_field_d = 1'b0;

        unique case (state_q)
            S_INIT: begin
                if (start_edge) begin
                    lives_d       = LIVES_INIT;
                    level_d       = '0;
                    cnt_d         = PAUSE_CNT;
                    reset_field_d = 1'b1;
                    state_d       = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (frame_tick) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                    // serve is registered so it lands on the first cycle of play
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_PLAY;
                        serve_d = 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (bricks_clear) begin
                    if (level_q < LAST_LEVEL) begin
                        level_d       = level_q + LEVEL_W'(1);
                        reset_field_d = 1'b1;
                        cnt_d         = PAUSE_CNT;
                        state_d       = S_PAUSE;
                    end else begin
                        cnt_d   = HOLD_CNT;
                        state_d = S_WIN;
                    end
                end else if (ball_lost) begin
                    if (lives_q > LIVES_W'(1)) begin
                        lives_d = lives_q - LIVES_W'(1);
                        cnt_d   = PAUSE_CNT;
                        state_d = S_PAUSE;
                    end else begin
                        lives_d = '0;
                        cnt_d   = HOLD_CNT;
                        state_d = S_DEAD;
                    end
                end
            end
            S_DEAD, S_WIN: begin
                // a press during the hold window is dropped, not remembered
                if (cnt_q == '0 && start_edge) begin
                    reset_field_d = 1'b1;
                    state_d       = S_INIT;
                end else if (frame_tick && cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign init        = (state_q == S_INIT);
    assign dead        = (state_q == S_DEAD);
    assign win         = (state_q == S_WIN);
    assign play        = (state_q == S_PLAY);
    assign serve       = serve_q;
    assign reset_field = reset_field_q;
    assign lives       = lives_q;
    assign level       = level_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench: vector table on a short-timing instance, directed and random runs on a default one.
module tb_game_state_ctrl;

    localparam int T_LIVES  = 3;
    localparam int T_LEVELS = 3;
    localparam int T_PAUSE  = 60;
    localparam int T_HOLD   = 120;

    localparam int PH_TITLE = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_PLAY  = 2;
    localparam int PH_OVER  = 3;
    localparam int PH_VICT  = 4;

    logic       clk;
    logic       rst_n;
    logic       frame_tick, start_btn, ball_lost, bricks_clear;
    logic       init, dead, win, play, serve, reset_field;
    logic [1:0] lives, level;

    logic       ft0, sb0, bl0, bc0;
    logic       init0, dead0, win0, play0, serve0, rf0;
    logic [1:0] lives0, level0;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    int m_ph, m_cnt, m_lives, m_level;
    bit m_prev, m_serve, m_rf;

    typedef struct {
        bit       ft, sb, bl, bc;
        bit [9:0] exp;
    } vec_t;
    vec_t vq[$];

    game_state_ctrl #(
        .LIVES        (T_LIVES),
        .LEVELS       (T_LEVELS),
        .PAUSE_FRAMES (T_PAUSE),
        .HOLD_FRAMES  (T_HOLD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .start_btn    (start_btn),
        .ball_lost    (ball_lost),
        .bricks_clear (bricks_clear),
        .init         (init),
        .dead         (dead),
        .win          (win),
        .play         (play),
        .serve        (serve),
        .reset_field  (reset_field),
        .lives        (lives),
        .level        (level)
    );

    game_state_ctrl #(
        .LIVES        (1),
        .LEVELS       (2),
        .PAUSE_FRAMES (2),
        .HOLD_FRAMES  (0)
    ) dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (ft0),
        .start_btn    (sb0),
        .ball_lost    (bl0),
        .bricks_clear (bc0),
        .init         (init0),
        .dead         (dead0),
        .win          (win0),
        .play         (play0),
        .serve        (serve0),
        .reset_field  (rf0),
        .lives        (lives0),
        .level        (level0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input bit ft, sb, bl, bc, i, d, w, p, s, r,
                                input int lv, input int lev);
        vec_t v;
        v.ft = ft; v.sb = sb; v.bl = bl; v.bc = bc;
        v.exp = {i, d, w, p, s, r, 2'(lv), 2'(lev)};
        return v;
    endfunction

    function automatic logic [9:0] dut_vec();
        return {init, dead, win, play, serve, reset_field, lives, level};
    endfunction

    function automatic logic [9:0] model_vec();
        return {m_ph == PH_TITLE, m_ph == PH_OVER, m_ph == PH_VICT, m_ph == PH_PLAY,
                m_serve, m_rf, 2'(m_lives), 2'(m_level)};
    endfunction

    task automatic model_reset();
        m_ph = PH_TITLE; m_cnt = 0; m_lives = T_LIVES; m_level = 0;
        m_prev = 1'b1; m_serve = 1'b0; m_rf = 1'b0;
    endtask

    task automatic model_clock(input bit ft, input bit sb, input bit bl, input bit bc);
        bit pressed;
        pressed = sb && !m_prev;
        m_prev  = sb;
        m_serve = 1'b0;
        m_rf    = 1'b0;
        case (m_ph)
            PH_TITLE: if (pressed) begin
                m_lives = T_LIVES; m_level = 0; m_cnt = T_PAUSE; m_rf = 1'b1; m_ph = PH_WAIT;
            end
            PH_WAIT: if (ft) begin
                if (m_cnt == 1) begin m_ph = PH_PLAY; m_serve = 1'b1; end
                m_cnt = m_cnt - 1;
            end
            PH_PLAY: begin
                if (bc) begin
                    if (m_level + 1 < T_LEVELS) begin
                        m_level++; m_rf = 1'b1; m_cnt = T_PAUSE; m_ph = PH_WAIT;
                    end else begin
                        m_cnt = T_HOLD; m_ph = PH_VICT;
                    end
                end else if (bl) begin
                    m_lives--;
                    m_cnt = (m_lives == 0) ? T_HOLD : T_PAUSE;
                    m_ph  = (m_lives == 0) ? PH_OVER : PH_WAIT;
                end
            end
            default: begin
                if (m_cnt == 0 && pressed) begin
                    m_ph = PH_TITLE; m_rf = 1'b1;
                end else if (ft && m_cnt > 0) begin
                    m_cnt--;
                end
            end
        endcase
    endtask

    task automatic check_model(input string name);
        chk(name, dut_vec(), model_vec());
        chk("banner_excl", $countones({init, dead, win}) <= 1, 1);
    endtask

    task automatic step(input bit ft, input bit sb, input bit bl, input bit bc);
        frame_tick = ft; start_btn = sb; ball_lost = bl; bricks_clear = bc;
        @(posedge clk);
        model_clock(ft, sb, bl, bc);
        #1;
        check_model("model");
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        frame_tick = 0; start_btn = 1; ball_lost = 0; bricks_clear = 0;
        ft0 = 0; sb0 = 1; bl0 = 0; bc0 = 0;
        model_reset();

        // Short-timing instance: LIVES=1, LEVELS=2, PAUSE=2, HOLD=0
        vq.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vq.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        vq.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1));
        vq.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1));
        vq.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1));
        vq.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
        vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1));
        vq.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1));
        vq.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1));

        #12;
        chk("reset_state", dut_vec(), 10'b1000001100);
        chk("reset_state0", {init0, dead0, win0, play0, serve0, rf0, lives0, level0},
            10'b1000000100);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            ft0 = vq[i].ft; sb0 = vq[i].sb; bl0 = vq[i].bl; bc0 = vq[i].bc;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                {init0, dead0, win0, play0, serve0, rf0, lives0, level0}, vq[i].exp);
            chk("banner_excl0", $countones({init0, dead0, win0}) <= 1, 1);
        end

        // Default instance: start held through reset must not start a game
        #2 rst_n = 1'b0;
        start_btn = 1'b1;
        model_reset();
        #1 check_model("reset_again");
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        chk("held_no_start", {init, reset_field}, 2'b10);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("start_rf", {init, reset_field}, 2'b01);
        step(0, 0, 0, 0);
        chk("rf_one_cycle", reset_field, 0);
        frames(59);
        chk("pause_59", play, 0);
        frames(1);
        chk("serve_60", {play, serve}, 2'b11);
        step(0, 0, 0, 0);
        chk("serve_one_cycle", {play, serve}, 2'b10);

        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 0);
            chk($sformatf("lives_after_%0d", k + 1), lives, 2 - k);
            if (k < 2) begin
                frames(60);
                chk("reserve", {play, serve}, 2'b11);
            end
        end
        chk("dead_banner", {dead, play}, 2'b10);
        frames(119);
        step(0, 1, 0, 0);
        chk("early_start_ignored", {dead, init}, 2'b10);
        step(0, 0, 0, 0);
        frames(1);
        chk("still_dead", dead, 1);
        step(0, 1, 0, 0);
        chk("restart_init", {init, reset_field, dead}, 3'b110);

        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        frames(60);
        chk("serve_lvl0", {play, serve}, 2'b11);
        for (int j = 0; j < 3; j++) begin
            step(0, 0, 0, 1);
            if (j < 2) begin
                chk("level_up", level, j + 1);
                chk("level_up_rf", {reset_field, play}, 2'b10);
                frames(60);
                chk("serve_next_level", {play, serve}, 2'b11);
            end else begin
                chk("win_banner", {win, play, level}, 4'b1010);
            end
        end

        frames(120);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("win_to_init", {init, reset_field}, 2'b11);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        frames(60);
        step(0, 0, 1, 0);
        frames(60);
        step(0, 0, 0, 1);
        frames(60);
        chk("pre_reset", {play, lives, level}, 5'b11001);

        // Asynchronous reset mid-play, no clock edge needed
        #2 rst_n = 1'b0;
        #1 chk("async_reset", dut_vec(), 10'b1000001100);
        model_reset();
        @(posedge clk);
        #1 check_model("held_reset");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            chk("no_pulse_after_reset", {serve, reset_field}, 2'b00);
        end

        begin
            bit sb_r;
            sb_r = 1'b0;
            for (int c = 0; c < 4000; c++) begin
                if ($urandom_range(0, 499) == 0) begin
                    #2 rst_n = 1'b0;
                    model_reset();
                    #1 check_model("rand_reset");
                    @(posedge clk);
                    #3 rst_n = 1'b1;
                end
                if ($urandom_range(0, 7) == 0) sb_r = !sb_r;
                step(1'($urandom_range(0, 1)), sb_r, $urandom_range(0, 31) == 0,
                     $urandom_range(0, 39) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
